lab2_proc_mem_responder: RTL



---
 rtl/lab2_proc_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lab2_proc_mem_responder.sv
// Single-slot memory responder: request fire at edge t gives ostream_val from cycle t+1+p_latency; holds response under backpressure.
// Define LAB2_PROC_MEM_RESPONDER_RANGE_CHECK_EN to flag addresses >= p_mem_nbytes (test=2'b01, no write) instead of wrapping.
module lab2_proc_mem_responder #(
   parameter int unsigned p_mem_nbytes = 4096,
   parameter int unsigned p_latency    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [76:0] istream_msg,
   input  logic        istream_val,
   output logic        istream_rdy,
   output logic [46:0] ostream_msg,
   output logic        ostream_val,
   input  logic        ostream_rdy
);

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } req_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } resp_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int unsigned AW     = $clog2(p_mem_nbytes);
   localparam int unsigned NWORDS = p_mem_nbytes / 4;
   localparam logic [3:0]  LAT_M1 = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   resp_t         resp_q, resp_d, resp_new;
   logic [31:0]   mem_q [NWORDS];

   req_t          req;
   logic [AW-3:0] widx;
   logic [1:0]    off;
   logic [3:0]    lenmask;
   logic [3:0]    be;
   logic [31:0]   rd_word, rd_data, rd_mask, wdata_sh, wr_word;
   logic          is_wr, oor, req_fire, resp_fire;

   assign req  = istream_msg;
   assign widx = req.addr[AW-1:2];
   assign off  = req.addr[1:0];

`ifdef LAB2_PROC_MEM_RESPONDER_RANGE_CHECK_EN
   logic oor_seen_q;
   assign oor = (req.addr >= 32'(p_mem_nbytes));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         oor_seen_q <= 1'b0;
      else if (req_fire && oor)
         oor_seen_q <= 1'b1;
   end
`else
   logic unused_addr_hi;
   assign oor            = 1'b0;
   assign unused_addr_hi = ^req.addr[31:AW];
`endif

   assign is_wr     = (req.type_ == 3'd1) || (req.type_ == 3'd2);
   assign req_fire  = istream_val && istream_rdy;
   assign resp_fire = ostream_val && ostream_rdy;
   assign rd_word   = mem_q[widx];

   // Byte lanes touched: len bytes starting at off, clipped at the word boundary by the 4-bit shift.
   always_comb begin
      case (req.len)
         2'd1:    lenmask = 4'b0001;
         2'd2:    lenmask = 4'b0011;
         2'd3:    lenmask = 4'b0111;
         default: lenmask = 4'b1111;
      endcase
      be       = lenmask << off;
      wdata_sh = req.data << {off, 3'b000};
      rd_mask  = '0;
      wr_word  = rd_word;
      for (int j = 0; j < 4; j++) begin
         rd_mask[8*j +: 8] = {8{lenmask[j]}};
         if (be[j])
            wr_word[8*j +: 8] = wdata_sh[8*j +: 8];
      end
      rd_data = (rd_word >> {off, 3'b000}) & rd_mask;
   end

   always_comb begin
      resp_new.type_  = req.type_;
      resp_new.opaque = req.opaque;
      resp_new.len    = req.len;
      resp_new.test   = oor ? 2'b01 : 2'b00;
      resp_new.data   = (oor || is_wr) ? 32'h0 : rd_data;
   end

   always_ff @(posedge clk) begin
      if (req_fire && is_wr && !oor)
         mem_q[widx] <= wr_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == 4'd0)
               state_d = S_RESP;
            else
               cnt_d = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (resp_fire)
               state_d = S_IDLE;
         end
         default: ;
      endcase
      // A request fire in RESP overrides the return to IDLE (back-to-back accept).
      if (req_fire) begin
         state_d = (p_latency > 0) ? S_WAIT : S_RESP;
         cnt_d   = LAT_M1;
         resp_d  = resp_new;
      end
   end

   always_comb begin
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      if (reset) begin
         case (state_q)
            S_IDLE: istream_rdy = 1'b1;
            S_RESP: begin
               ostream_val = 1'b1;
               istream_rdy = ostream_rdy;
            end
            default: ;
         endcase
      end
   end

   assign ostream_msg = resp_q;

endmodule
